// File: rtl/bitslip_align_ctrl.sv
// rtl/bitslip_align_ctrl.sv - lock/qualify/monitor/retry sequencer for one raw-mode bitslip aligner
// Optional slip-offset monitor: BITSLIP_ALIGN_CTRL_SLIP_CHECK_EN
module bitslip_align_ctrl #(
  parameter int RST_CYCLES     = 16,
  parameter int SEARCH_TIMEOUT = 4096,
  parameter int QUAL_CYCLES    = 256,
  parameter int ERR_WINDOW     = 1024,
  parameter int ERR_THRESH     = 4,
  parameter int MAX_RETRY      = 8
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        start,
  input  logic        align_locked,
  input  logic        align_error,
  input  logic [7:0]  align_bitslip_value,
  output logic        align_rstn,
  output logic        align_en,
  output logic        link_up,
  output logic        fail,
  output logic [2:0]  state_o,
  output logic [3:0]  retry_count,
  output logic [15:0] err_count,
  output logic [7:0]  bitslip_latched
`ifdef BITSLIP_ALIGN_CTRL_SLIP_CHECK_EN
  ,
  output logic        slip_event
`endif
);

  localparam int TMAX_SQ = (SEARCH_TIMEOUT > QUAL_CYCLES) ? SEARCH_TIMEOUT : QUAL_CYCLES;
  localparam int TMAX    = (TMAX_SQ > RST_CYCLES) ? TMAX_SQ : RST_CYCLES;
  localparam int TW      = $clog2(TMAX + 1);
  localparam int WW      = (ERR_WINDOW > 1) ? $clog2(ERR_WINDOW) : 1;
  localparam int EW      = $clog2(ERR_THRESH + 1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ARST    = 3'd1,
    S_SEARCH  = 3'd2,
    S_QUALIFY = 3'd3,
    S_UP      = 3'd4,
    S_RETRY   = 3'd5,
    S_FAIL    = 3'd6
  } state_t;

  state_t        r_state;
  state_t        w_next;
  logic [TW-1:0] r_timer;
  logic [WW-1:0] r_win;
  logic [EW-1:0] r_werr;
  logic [3:0]    r_retry;
  logic [15:0]   r_err;
  logic [7:0]    r_bitslip;

  logic          r_align_rstn;
  logic          r_align_en;
  logic          r_link_up;
  logic          r_fail;
  logic [2:0]    r_state_o;

  logic          w_win_wrap;
  logic [EW-1:0] w_werr_next;
  logic [3:0]    w_retry_inc;
  logic          w_slip_mis;
  logic          w_align_rstn;
  logic          w_align_en;
  logic          w_link_up;
  logic          w_fail;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  // An error on the wrap cycle belongs to the window that starts there.
  always_comb begin
    w_win_wrap  = (r_win == WW'(ERR_WINDOW - 1));
    w_werr_next = w_win_wrap ? EW'(align_error) : (r_werr + EW'(align_error));
    w_retry_inc = (r_retry == 4'hF) ? r_retry : (r_retry + 4'd1);
`ifdef BITSLIP_ALIGN_CTRL_SLIP_CHECK_EN
    w_slip_mis  = (align_bitslip_value != r_bitslip);
`else
    w_slip_mis  = 1'b0;
`endif
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:    if (start) w_next = S_ARST;
      S_ARST:    if (r_timer == '0) w_next = S_SEARCH;
      S_SEARCH: begin
        if (align_locked)        w_next = S_QUALIFY;
        else if (r_timer == '0)  w_next = S_RETRY;
      end
      S_QUALIFY: begin
        if (!align_locked || align_error) w_next = S_RETRY;
        else if (r_timer == '0)           w_next = S_UP;
      end
      S_UP: begin
        if (!align_locked || (w_werr_next >= EW'(ERR_THRESH)) || w_slip_mis)
          w_next = S_RETRY;
      end
      S_RETRY:   w_next = (int'(w_retry_inc) >= MAX_RETRY) ? S_FAIL : S_ARST;
      S_FAIL:    w_next = S_FAIL;
      default:   w_next = S_IDLE;
    endcase
    if (!start) w_next = S_IDLE;
  end

  // One down-counter serves ARST, SEARCH and QUALIFY; it is reloaded on every state entry.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_timer   <= '0;
      r_win     <= '0;
      r_werr    <= '0;
      r_retry   <= '0;
      r_err     <= '0;
      r_bitslip <= '0;
    end else begin
      if (w_next != r_state) begin
        case (w_next)
          S_ARST:    r_timer <= TW'(RST_CYCLES - 1);
          S_SEARCH:  r_timer <= TW'(SEARCH_TIMEOUT - 1);
          S_QUALIFY: r_timer <= TW'(QUAL_CYCLES - 1);
          default:   r_timer <= '0;
        endcase
      end else if (r_timer != '0) begin
        r_timer <= r_timer - TW'(1);
      end

      if (r_state == S_UP) begin
        r_win  <= w_win_wrap ? '0 : (r_win + WW'(1));
        r_werr <= w_werr_next;
      end else begin
        r_win  <= '0;
        r_werr <= '0;
      end

      if (r_state == S_IDLE && w_next == S_ARST) begin
        r_retry <= '0;
        r_err   <= '0;
      end else begin
        if (r_state == S_RETRY) r_retry <= w_retry_inc;
        if (r_state == S_UP && align_error && r_err != 16'hFFFF) r_err <= r_err + 16'd1;
      end

      if (r_state == S_QUALIFY && w_next == S_UP) r_bitslip <= align_bitslip_value;
    end
  end

  always_comb begin
    w_align_rstn = 1'b0;
    w_align_en   = 1'b0;
    w_link_up    = 1'b0;
    w_fail       = 1'b0;
    case (r_state)
      S_SEARCH, S_QUALIFY: begin
        w_align_rstn = 1'b1;
        w_align_en   = 1'b1;
      end
      S_UP: begin
        w_align_rstn = 1'b1;
        w_align_en   = 1'b1;
        w_link_up    = 1'b1;
      end
      S_FAIL:  w_fail = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_align_rstn <= 1'b0;
      r_align_en   <= 1'b0;
      r_link_up    <= 1'b0;
      r_fail       <= 1'b0;
      r_state_o    <= 3'd0;
    end else begin
      r_align_rstn <= w_align_rstn;
      r_align_en   <= w_align_en;
      r_link_up    <= w_link_up;
      r_fail       <= w_fail;
      r_state_o    <= r_state;
    end
  end

`ifdef BITSLIP_ALIGN_CTRL_SLIP_CHECK_EN
  logic r_slip_event;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) r_slip_event <= 1'b0;
    else       r_slip_event <= (r_state == S_UP) && start && w_slip_mis;
  end

  assign slip_event = r_slip_event;
`endif

  assign align_rstn      = r_align_rstn;
  assign align_en        = r_align_en;
  assign link_up         = r_link_up;
  assign fail            = r_fail;
  assign state_o         = r_state_o;
  assign retry_count     = r_retry;
  assign err_count       = r_err;
  assign bitslip_latched = r_bitslip;

endmodule

// File: doc/bitslip_align_ctrl.md
Name: bitslip_align_ctrl

Overview:
Sequencer that owns the raw-mode bitslip aligner of one GTF RX channel. It performs these steps:
- resets and enables the aligner;
- qualifies its lock over a programmable window;
- monitors PRBS error bursts while the link is up;
- retries the alignment a bounded number of times before declaring failure.

It sits between the rx_mon control/status registers and the aligner instance.

Parameters:
RST_CYCLES, 16, cycles align_rstn is held low per attempt (>=1)
SEARCH_TIMEOUT, 4096, max cycles in SEARCH waiting for align_locked
QUAL_CYCLES, 256, consecutive cycles of clean lock required before link_up
ERR_WINDOW, 1024, length of error-rate observation window in UP
ERR_THRESH, 4, align_error pulses within one window that force a retry (>=1)
MAX_RETRY, 8, failed attempts before entering FAIL (>=1)

Ports:
clk  in  1  RX user clock, same as the aligner
rstn  in  1  asynchronous active-low reset
start  in  1  level; 1 = run the sequence, 0 = return to IDLE from any state
align_locked  in  1  aligner locked flag
align_error  in  1  aligner per-cycle PRBS mismatch pulse
align_bitslip_value  in  8  aligner current slip offset
align_rstn  out  1  synchronous active-low reset to the aligner
align_en  out  1  aligner enable
link_up  out  1  1 only in state UP
fail  out  1  1 only in state FAIL
state_o  out  3  current state encoding
retry_count  out  4  failed attempts since leaving IDLE, saturating at 15
err_count  out  16  total align_error pulses while in UP, saturating at 0xFFFF
bitslip_latched  out  8  align_bitslip_value captured on QUALIFY->UP

Behaviour:
- Reset (rstn=0, async): state=IDLE.
- Reset values of outputs:
  - align_rstn=0, align_en=0, link_up=0, fail=0;
  - retry_count=0, err_count=0, bitslip_latched=0;
  - all timers=0.
- All outputs are registered and change one cycle after the causing state transition.
- State encodings: IDLE=0, ARST=1, SEARCH=2, QUALIFY=3, UP=4, RETRY=5, FAIL=6.
- IDLE:
  - align_rstn=0, align_en=0.
  - If start=1: go to ARST and clear retry_count and err_count.
- ARST:
  - align_rstn=0 for exactly RST_CYCLES cycles, then go to SEARCH.
- SEARCH:
  - align_rstn=1, align_en=1, timer loaded with SEARCH_TIMEOUT.
  - If align_locked=1: go to QUALIFY.
  - If the timer expires first: go to RETRY.
- QUALIFY:
  - Counter counts consecutive cycles with align_locked=1 and align_error=0.
  - Any cycle with align_locked=0 or align_error=1: go to RETRY.
  - On reaching QUAL_CYCLES: go to UP and latch bitslip_latched.
- UP:
  - link_up=1.
  - Free-running window counter wraps at ERR_WINDOW-1. The window error counter resets to 0 at the wrap cycle; an error on that same cycle counts into the new window.
  - If the window error count reaches ERR_THRESH: go to RETRY.
  - If align_locked=0: go to RETRY immediately.
  - err_count increments on every align_error=1 cycle spent in UP.
- RETRY:
  - Single cycle; retry_count+1.
  - If the new value is >= MAX_RETRY: go to FAIL, else go to ARST.
  - align_rstn is driven 0 in this cycle.
- FAIL:
  - align_rstn=0, align_en=0, fail=1.
  - Held until start=0.
- start=0 in any state: go to IDLE next cycle. This has priority over every other transition.
- Counters retain their values in IDLE until the next start; bitslip_latched is never cleared except by rstn.
- align_error arriving on the same cycle as align_locked falling in UP produces a single retry; err_count still increments.
- Async reset mid-operation: outputs go to reset values immediately. align_rstn=0 guarantees the aligner is also reset.

Optional Feature:
Macro BITSLIP_ALIGN_CTRL_SLIP_CHECK_EN.
- Defined:
  - In UP, if align_bitslip_value differs from bitslip_latched, go to RETRY.
  - Adds output slip_event (1 bit). slip_event pulses for one cycle on that transition.
- Undefined:
  - align_bitslip_value is only sampled at the QUALIFY->UP transition.
  - No slip_event port exists.

Test Plan:
1. start=1, aligner model locks 40 cycles after release, clean PRBS:
   - align_rstn low exactly 16 cycles;
   - link_up=1 after 256 qualify cycles;
   - bitslip_latched = model offset (e.g. 0x05);
   - retry_count=0.
2. Aligner never locks:
   - 8 SEARCH timeouts of 4096 cycles each;
   - retry_count=8, fail=1, align_en=0.
   - Then deassert start: IDLE, fail=0, retry_count stays 8.
3. In UP, inject 3 errors within 1024 cycles: stays UP, err_count=3. Then inject 4 errors in the next window: RETRY, retry_count=1, relock to UP.
4. Lock drop at cycle 100 of QUALIFY: RETRY. Second attempt clean: UP with retry_count=1.
5. Error timing at window boundaries: inject an error on the wrap cycle plus 3 more in the same window: retry. Split 2+2 across windows: no retry.
6. rstn asserted while in UP: all outputs at reset values asynchronously. With SLIP_CHECK_EN, an offset change 0x05->0x06 in UP gives a slip_event pulse and RETRY.
